// File: rtl/fp_sum_pkg.sv
// Shared definitions for the fp32 sum feeder.
//   FP_W    : fp32 word width
//   FP_ZERO : +0.0 encoding used to pad unwritten lanes
//   tag_t   : per-frame sideband travelling alongside the adder tree
//   state_t : feeder control states
package fp_sum_pkg;

  localparam int          FP_W    = 32;
  localparam logic [31:0] FP_ZERO = 32'h0;

  typedef struct packed {
    logic valid;  // slot carries a real frame
    logic first;  // frame is the first of its vector
    logic last;   // frame closes its vector
  } tag_t;

  typedef enum logic [1:0] {
    ST_FILL,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/fp_sum_tag_pipe.sv
// Enabled shift register of frame tags, LATENCY deep, mirroring the
// enabled-cycle depth of the downstream adder tree.
//   i_clk  : clock
//   i_rst  : synchronous active-high reset, clears every tag
//   i_en   : advance enable (same enable the adder tree sees)
//   i_tag  : tag entering stage 1
//   o_exit : tag at stage LATENCY, aligned with the frame leaving the tree
module fp_sum_tag_pipe
  import fp_sum_pkg::*;
#(
  parameter int LATENCY = 5
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  tag_t i_tag,
  output tag_t o_exit
);

  tag_t r_tag [1:LATENCY];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 1; k <= LATENCY; k++) r_tag[k] <= '0;
    end else if (i_en) begin
      // stage boundary: entry -> stage 1, stage k-1 -> stage k
      r_tag[1] <= i_tag;
      for (int k = 2; k <= LATENCY; k++) r_tag[k] <= r_tag[k-1];
    end
  end

  assign o_exit = r_tag[LATENCY];

endmodule

// File: rtl/fp_sum_feeder.sv
// Packs a serial stream of fp32 words into LANES-wide frames for the
// adder-tree sum pipeline, steps the tree once per frame, drains it after
// the final frame and emits accumulate/save strobes and a done pulse.
//   aclk, areset : clock, synchronous active-high reset
//   s_tdata/s_tvalid/s_tready/s_tlast : input word stream (one vector)
//   lanes_out    : frame presented to the tree, lane k at [32k+31:32k]
//   clock_en     : tree advance enable
//   acc_sign     : exiting frame is added to the accumulator
//   save_sign    : exiting frame result is captured
//   m_done       : one-cycle pulse, vector result complete
//   busy         : a vector is in progress
module fp_sum_feeder
  import fp_sum_pkg::*;
#(
  parameter int LANES   = 16,
  parameter int LATENCY = 5
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [FP_W-1:0]       s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic                  s_tlast,
  output logic [FP_W*LANES-1:0] lanes_out,
  output logic                  clock_en,
  output logic                  acc_sign,
  output logic                  save_sign,
  output logic                  m_done,
  output logic                  busy
);

  localparam int IDX_W = $clog2(LANES);

  state_t                     r_state, w_next;
  logic [IDX_W-1:0]           r_idx;
  logic [LANES-1:0][FP_W-1:0] r_buf, w_buf, r_lanes;
  logic                       r_tready, r_clk_en, r_done, r_busy;
  logic                       r_last, r_first;
  logic                       w_beat, w_close;
  tag_t                       w_tag_in, w_exit;

  assign w_beat  = s_tvalid & r_tready;
  assign w_close = w_beat & ((r_idx == IDX_W'(LANES-1)) | s_tlast);

  // Buffer contents after this cycle's beat; the first beat of a frame
  // wipes stale lanes so a short tail frame is zero-padded.
  always_comb begin
    w_buf = r_buf;
    if (r_idx == '0) begin
      for (int k = 0; k < LANES; k++) w_buf[k] = FP_ZERO;
    end
    w_buf[r_idx] = s_tdata;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_FILL:  if (w_close) w_next = ST_ISSUE;
      ST_ISSUE: w_next = r_last ? ST_DRAIN : ST_FILL;
      // the last-tagged frame leaves the tree this cycle
      ST_DRAIN: if (r_clk_en & w_exit.valid & w_exit.last) w_next = ST_DONE;
      ST_DONE:  w_next = ST_FILL;
      default:  w_next = ST_FILL;
    endcase
  end

  always_comb begin
    w_tag_in = '0;
    if (r_state == ST_ISSUE) begin
      w_tag_in.valid = 1'b1;
      w_tag_in.first = r_first;
      w_tag_in.last  = r_last;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state  <= ST_FILL;
      r_idx    <= '0;
      r_buf    <= '0;
      r_lanes  <= '0;
      r_tready <= 1'b1;
      r_clk_en <= 1'b0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
      r_last   <= 1'b0;
      r_first  <= 1'b1;
    end else begin
      r_state  <= w_next;
      // outputs registered from the next state so they line up with it
      r_tready <= (w_next == ST_FILL);
      r_clk_en <= (w_next == ST_ISSUE) || (w_next == ST_DRAIN);
      r_done   <= (w_next == ST_DONE);
      r_lanes  <= w_close ? w_buf : '0;
      if (w_beat) begin
        r_buf  <= w_buf;
        r_idx  <= w_close ? '0 : r_idx + 1'b1;
        r_busy <= 1'b1;
      end else if (r_state == ST_DONE) begin
        r_busy <= 1'b0;
      end
      if (w_close) r_last <= s_tlast;
      // after a vector's last frame the next frame opens a new vector
      if (r_state == ST_ISSUE) r_first <= r_last;
    end
  end

  fp_sum_tag_pipe #(
    .LATENCY (LATENCY)
  ) u_tag_pipe (
    .i_clk  (aclk),
    .i_rst  (areset),
    .i_en   (r_clk_en),
    .i_tag  (w_tag_in),
    .o_exit (w_exit)
  );

  assign s_tready  = r_tready;
  assign lanes_out = r_lanes;
  assign clock_en  = r_clk_en;
  assign m_done    = r_done;
  assign busy      = r_busy;
  assign save_sign = r_clk_en & w_exit.valid;
  assign acc_sign  = r_clk_en & w_exit.valid & ~w_exit.first;

endmodule

// File: tb/tb_fp_sum_feeder.sv
module tb_fp_sum_feeder;

  localparam int LANES   = 16;
  localparam int LATENCY = 5;
  localparam int FW      = 32 * LANES;

  logic          aclk = 1'b0;
  logic          areset;
  logic [31:0]   s_tdata;
  logic          s_tvalid;
  logic          s_tready;
  logic          s_tlast;
  logic [FW-1:0] lanes_out;
  logic          clock_en, acc_sign, save_sign, m_done, busy;

  always #5 aclk = ~aclk;

  fp_sum_feeder #(.LANES(LANES), .LATENCY(LATENCY)) dut (
    .aclk      (aclk),
    .areset    (areset),
    .s_tdata   (s_tdata),
    .s_tvalid  (s_tvalid),
    .s_tready  (s_tready),
    .s_tlast   (s_tlast),
    .lanes_out (lanes_out),
    .clock_en  (clock_en),
    .acc_sign  (acc_sign),
    .save_sign (save_sign),
    .m_done    (m_done),
    .busy      (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge aclk) cyc <= cyc + 1;

  // observation log
  logic [FW-1:0] mon_frames[$];
  int            mon_issue_en[$];
  int            mon_issue_cyc[$];
  int            mon_save_en[$];
  int            mon_save_cyc[$];
  bit            mon_acc[$];
  int            mon_done[$];
  int            en_cnt = 0;
  int            viol   = 0;
  bit            prev_en = 1'b0;

  always @(negedge aclk) begin
    if (areset) begin
      prev_en = 1'b0;
    end else begin
      if (clock_en) begin
        en_cnt++;
        if (!prev_en) begin
          mon_frames.push_back(lanes_out);
          mon_issue_en.push_back(en_cnt);
          mon_issue_cyc.push_back(cyc);
        end else if (lanes_out != '0) begin
          viol++;
        end
        if (s_tready) viol++;
      end
      if (save_sign) begin
        mon_save_en.push_back(en_cnt);
        mon_save_cyc.push_back(cyc);
        mon_acc.push_back(acc_sign);
        if (!clock_en) viol++;
      end
      if (acc_sign && !save_sign) viol++;
      if (m_done) mon_done.push_back(cyc);
      prev_en = clock_en;
    end
  end

  // scenario stimulus and per-scenario log offsets
  logic [31:0] vw[$];
  int          vl[$];
  int          beat_first[$];
  int          beat_last[$];
  int b_frames, b_save, b_done, b_en, b_viol;

  task automatic sb_start();
    b_frames = mon_frames.size();
    b_save   = mon_save_en.size();
    b_done   = mon_done.size();
    b_en     = en_cnt;
    b_viol   = viol;
  endtask

  function automatic logic [31:0] rnd_word();
    logic [31:0] w;
    w = $urandom;
    if (w == 32'h0) w = 32'h1;
    return w;
  endfunction

  // mode 0: valid always, 1: valid every other cycle, 2: random gaps
  task automatic drive(input int mode);
    int p = 0;
    bit tog = 1'b1;
    beat_first.delete();
    beat_last.delete();
    for (int v = 0; v < vl.size(); v++) begin
      for (int i = 0; i < vl[v]; i++) begin
        bit got = 1'b0;
        int guard = 0;
        while (!got) begin
          bit want;
          bit hs;
          @(negedge aclk);
          case (mode)
            0:       want = 1'b1;
            1:       begin want = tog; tog = ~tog; end
            default: want = ($urandom_range(0, 99) >= 30);
          endcase
          s_tvalid = want;
          s_tdata  = vw[p];
          s_tlast  = (i == vl[v] - 1);
          hs = want && s_tready;
          if (hs && i == 0)         beat_first.push_back(cyc);
          if (hs && i == vl[v] - 1) beat_last.push_back(cyc);
          @(posedge aclk);
          got = hs;
          guard++;
          if (!got && guard > 500) begin
            n_cmp++; n_bad++;
            $display("FAIL drive_timeout: word %0d of vector %0d never accepted, s_tready=%0b required 1", i, v, s_tready);
            got = 1'b1;
          end
        end
        p++;
      end
    end
    @(negedge aclk);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_done();
    int g = 0;
    while (mon_done.size() < b_done + vl.size() && g < 400) begin
      @(negedge aclk);
      g++;
    end
    repeat (LATENCY + 4) @(negedge aclk);
  endtask

  // reference: frames are consecutive LANES-word chunks of each vector,
  // zero-padded; each exits LATENCY enabled cycles after issue; only the
  // first frame of a vector is not accumulated; done follows last save.
  task automatic scoreboard(input string name);
    logic [FW-1:0] ef[$];
    bit            efirst[$];
    int            lastf[$];
    int p = 0;
    int nfr, nsv, ndn;
    for (int v = 0; v < vl.size(); v++) begin
      int nf = (vl[v] + LANES - 1) / LANES;
      for (int f = 0; f < nf; f++) begin
        logic [FW-1:0] fr = '0;
        for (int k = 0; k < LANES; k++)
          if (f * LANES + k < vl[v]) fr[32*k +: 32] = vw[p + f * LANES + k];
        ef.push_back(fr);
        efirst.push_back(f == 0);
      end
      lastf.push_back(ef.size() - 1);
      p += vl[v];
    end
    nfr = mon_frames.size() - b_frames;
    nsv = mon_save_en.size() - b_save;
    ndn = mon_done.size() - b_done;

    n_cmp++;
    if (nfr !== ef.size()) begin
      n_bad++;
      $display("FAIL %s frame_count: got %0d expected %0d", name, nfr, ef.size());
    end
    for (int i = 0; i < nfr && i < ef.size(); i++) begin
      n_cmp++;
      if (mon_frames[b_frames + i] !== ef[i]) begin
        n_bad++;
        $display("FAIL %s frame%0d: got %h expected %h", name, i, mon_frames[b_frames + i], ef[i]);
      end
    end
    n_cmp++;
    if (nsv !== ef.size()) begin
      n_bad++;
      $display("FAIL %s save_count: got %0d expected %0d", name, nsv, ef.size());
    end
    for (int i = 0; i < nsv && i < nfr && i < ef.size(); i++) begin
      n_cmp++;
      if (mon_save_en[b_save + i] !== mon_issue_en[b_frames + i] + LATENCY) begin
        n_bad++;
        $display("FAIL %s save%0d_enabled_index: got %0d expected %0d", name, i,
                 mon_save_en[b_save + i], mon_issue_en[b_frames + i] + LATENCY);
      end
      n_cmp++;
      if (mon_acc[b_save + i] !== !efirst[i]) begin
        n_bad++;
        $display("FAIL %s acc%0d: got %0b expected %0b", name, i, mon_acc[b_save + i], !efirst[i]);
      end
    end
    n_cmp++;
    if (ndn !== vl.size()) begin
      n_bad++;
      $display("FAIL %s done_count: got %0d expected %0d", name, ndn, vl.size());
    end
    for (int v = 0; v < ndn && v < vl.size(); v++) begin
      if (lastf[v] < nsv) begin
        n_cmp++;
        if (mon_done[b_done + v] !== mon_save_cyc[b_save + lastf[v]] + 1) begin
          n_bad++;
          $display("FAIL %s done%0d_cycle: got %0d expected %0d", name, v,
                   mon_done[b_done + v], mon_save_cyc[b_save + lastf[v]] + 1);
        end
      end
    end
    n_cmp++;
    if (en_cnt - b_en !== ef.size() + LATENCY * vl.size()) begin
      n_bad++;
      $display("FAIL %s enabled_cycles: got %0d expected %0d", name, en_cnt - b_en,
               ef.size() + LATENCY * vl.size());
    end
    n_cmp++;
    if (viol - b_viol !== 0) begin
      n_bad++;
      $display("FAIL %s protocol_violations: got %0d expected 0", name, viol - b_viol);
    end
    n_cmp++;
    if (busy !== 1'b0 || s_tready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s idle_after: busy=%0b s_tready=%0b expected busy=0 s_tready=1", name, busy, s_tready);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    n_cmp++;
    if (s_tready !== 1'b1 || lanes_out !== '0 || clock_en !== 1'b0 || acc_sign !== 1'b0 ||
        save_sign !== 1'b0 || m_done !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s: tready=%0b lanes_nz=%0b en=%0b acc=%0b save=%0b done=%0b busy=%0b expected 1 0 0 0 0 0 0",
               name, s_tready, lanes_out != '0, clock_en, acc_sign, save_sign, m_done, busy);
    end
  endtask

  task automatic test_reset();
    areset = 1'b1;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check_reset_outputs("reset_held");
    areset = 1'b0;
    @(negedge aclk);
    check_reset_outputs("reset_released");
  endtask

  task automatic test_full_frame();
    vw.delete(); vl.delete();
    vl.push_back(16);
    for (int i = 0; i < 16; i++) vw.push_back(32'h3F80_0000);
    sb_start(); drive(0); wait_done(); scoreboard("full_frame");
  endtask

  task automatic test_two_frames();
    vw.delete(); vl.delete();
    vl.push_back(20);
    for (int i = 0; i < 20; i++) vw.push_back(32'h4000_0000);
    sb_start(); drive(0); wait_done(); scoreboard("two_frames");
  endtask

  task automatic test_single_word();
    vw.delete(); vl.delete();
    vl.push_back(1);
    vw.push_back(32'hBF80_0000);
    sb_start(); drive(0); wait_done(); scoreboard("single_word");
    n_cmp++;
    if (mon_done.size() <= b_done || beat_last.size() < 1) begin
      n_bad++;
      $display("FAIL single_word_done_timing: no done or no last beat observed, expected done at t+%0d", 2 + LATENCY);
    end else if (mon_done[b_done] !== beat_last[0] + 2 + LATENCY) begin
      n_bad++;
      $display("FAIL single_word_done_timing: got cycle %0d expected %0d", mon_done[b_done], beat_last[0] + 2 + LATENCY);
    end
  endtask

  task automatic test_toggle_valid();
    vw.delete(); vl.delete();
    vl.push_back(16);
    for (int i = 0; i < 16; i++) vw.push_back(rnd_word());
    sb_start(); drive(1); wait_done(); scoreboard("toggle_valid");
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 7; i++) begin
      @(negedge aclk);
      s_tvalid = 1'b1; s_tdata = rnd_word(); s_tlast = 1'b0;
      @(posedge aclk);
    end
    @(negedge aclk);
    s_tvalid = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_reset_busy_before: got %0b expected 1", busy);
    end
    areset = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    areset = 1'b0;
    check_reset_outputs("mid_reset_outputs");
    vw.delete(); vl.delete();
    vl.push_back(16);
    for (int i = 0; i < 16; i++) vw.push_back(rnd_word());
    sb_start(); drive(0); wait_done(); scoreboard("after_mid_reset");
  endtask

  task automatic test_back_to_back();
    vw.delete(); vl.delete();
    vl.push_back(32);
    vl.push_back(5);
    for (int i = 0; i < 37; i++) vw.push_back(rnd_word());
    sb_start(); drive(0); wait_done(); scoreboard("back_to_back");
    n_cmp++;
    if (mon_issue_cyc.size() < b_frames + 2) begin
      n_bad++;
      $display("FAIL b2b_issue_spacing: only %0d issues seen, expected 17-cycle spacing", mon_issue_cyc.size() - b_frames);
    end else if (mon_issue_cyc[b_frames + 1] - mon_issue_cyc[b_frames] !== 17) begin
      n_bad++;
      $display("FAIL b2b_issue_spacing: got %0d expected 17", mon_issue_cyc[b_frames + 1] - mon_issue_cyc[b_frames]);
    end
    n_cmp++;
    if (mon_done.size() <= b_done || beat_first.size() < 2) begin
      n_bad++;
      $display("FAIL b2b_next_accept: missing done or second vector start, expected accept at done+1");
    end else if (beat_first[1] !== mon_done[b_done] + 1) begin
      n_bad++;
      $display("FAIL b2b_next_accept: got cycle %0d expected %0d", beat_first[1], mon_done[b_done] + 1);
    end
  endtask

  task automatic test_random();
    vw.delete(); vl.delete();
    for (int v = 0; v < 3; v++) begin
      int n = $urandom_range(1, 40);
      vl.push_back(n);
      for (int i = 0; i < n; i++) vw.push_back(rnd_word());
    end
    sb_start(); drive(2); wait_done(); scoreboard("random");
  endtask

  initial begin
    areset   = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tlast  = 1'b0;
    test_reset();
    test_full_frame();
    test_two_frames();
    test_single_word();
    test_toggle_valid();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
